// File: rtl/operand_select_stage_pkg.sv
// Shared types for the decode-to-execute operand-select stage: operand/control
// encodings, forwarding-source descriptor and the registered output payload.
package operand_select_stage_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned FW_DEPTH_DEFAULT = 3;

  typedef logic [XLEN-1:0] UIntX;
  typedef logic [XLEN-1:0] Addr;
  typedef logic [31:0]     Inst;
  typedef logic [7:0]      IId;
  typedef logic [4:0]      RegIdx;

  localparam RegIdx REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_IMZ  = 2'd2,
    OP1_ZERO = 2'd3
  } Op1Sel;

  typedef enum logic [2:0] {
    OP2_RS2W = 3'd0,
    OP2_IMI  = 3'd1,
    OP2_IMS  = 3'd2,
    OP2_IMJ  = 3'd3,
    OP2_IMU  = 3'd4,
    OP2_ZERO = 3'd5
  } Op2Sel;

  typedef struct packed {
    Op1Sel      op1_sel;
    Op2Sel      op2_sel;
    logic [3:0] alu_op;
    logic       rf_we;
  } Ctrl;

  typedef struct packed {
    logic  valid;
    logic  can_forward;
    RegIdx addr;
    UIntX  wdata;
  } FwCtrl;

  typedef struct packed {
    Addr  pc;
    Inst  inst;
    IId   inst_id;
    Ctrl  ctrl;
    UIntX imm_i;
    UIntX imm_b;
    UIntX imm_j;
    UIntX op1_data;
    UIntX op2_data;
    UIntX rs2_data;
  } OutPayload;

  function automatic RegIdx rs1_of(input Inst inst);
    return inst[19:15];
  endfunction

  function automatic RegIdx rs2_of(input Inst inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/operand_select_stage_if.sv
// Decode-side and execute-side handshake bundle of the operand-select stage.
// The stage uses the slave view; the producer/consumer side uses master.
interface operand_select_stage_if;
  import operand_select_stage_pkg::*;

  logic in_valid;
  logic in_ready;
  Addr  in_pc;
  Inst  in_inst;
  IId   in_inst_id;
  Ctrl  in_ctrl;
  UIntX in_imm_i;
  UIntX in_imm_s;
  UIntX in_imm_b;
  UIntX in_imm_j;
  UIntX in_imm_u;
  UIntX in_imm_z;

  logic out_valid;
  logic out_ready;
  Addr  out_pc;
  Inst  out_inst;
  IId   out_inst_id;
  Ctrl  out_ctrl;
  UIntX out_imm_i;
  UIntX out_imm_b;
  UIntX out_imm_j;
  UIntX out_op1_data;
  UIntX out_op2_data;
  UIntX out_rs2_data;

  modport slave (
    input  in_valid, in_pc, in_inst, in_inst_id, in_ctrl,
    input  in_imm_i, in_imm_s, in_imm_b, in_imm_j, in_imm_u, in_imm_z,
    output in_ready,
    output out_valid, out_pc, out_inst, out_inst_id, out_ctrl,
    output out_imm_i, out_imm_b, out_imm_j,
    output out_op1_data, out_op2_data, out_rs2_data,
    input  out_ready
  );

  modport master (
    output in_valid, in_pc, in_inst, in_inst_id, in_ctrl,
    output in_imm_i, in_imm_s, in_imm_b, in_imm_j, in_imm_u, in_imm_z,
    input  in_ready,
    input  out_valid, out_pc, out_inst, out_inst_id, out_ctrl,
    input  out_imm_i, out_imm_b, out_imm_j,
    input  out_op1_data, out_op2_data, out_rs2_data,
    output out_ready
  );

endinterface

// File: rtl/operand_select_stage_fw_operand_resolve.sv
// Resolves one source register against the forwarding sources and the register
// file, and flags a hit on a source that cannot supply its data.
module fw_operand_resolve
  import operand_select_stage_pkg::*;
#(
  parameter int unsigned       NUM_FW        = FW_DEPTH_DEFAULT,
  parameter logic [NUM_FW-1:0] FW_NOFWD_MASK = NUM_FW'(1'b1)
) (
  input  RegIdx addr_i,
  input  UIntX  regfile_i [32],
  input  FwCtrl fw_i [NUM_FW],
  output UIntX  value_o,
  output logic  blocking_o
);

  logic hit_s;
  logic fwd_s;
  logic take_s;
  logic found_s;
  UIntX value_s;

  // Youngest forwardable hit wins; any non-forwardable hit blocks regardless of age.
  always_comb begin
    value_s    = regfile_i[addr_i];
    blocking_o = 1'b0;
    found_s    = 1'b0;
    hit_s      = 1'b0;
    fwd_s      = 1'b0;
    take_s     = 1'b0;
    for (int i = 0; i < NUM_FW; i++) begin
      hit_s      = fw_i[i].valid && (fw_i[i].addr == addr_i) && (addr_i != REG_ZERO);
      fwd_s      = fw_i[i].can_forward && !FW_NOFWD_MASK[i];
      blocking_o = blocking_o | (hit_s & ~fwd_s);
      take_s     = hit_s & fwd_s & ~found_s;
      value_s    = take_s ? fw_i[i].wdata : value_s;
      found_s    = found_s | take_s;
    end
    value_o = (addr_i == REG_ZERO) ? '0 : value_s;
  end

endmodule

// File: rtl/operand_select_stage.sv
// Operand-select stage between decode and execute: forwarding-aware operand
// resolution, hazard stall, registered valid/ready output and stall counter.
module operand_select_stage
  import operand_select_stage_pkg::*;
#(
  parameter int unsigned       NUM_FW        = FW_DEPTH_DEFAULT,
  parameter logic [NUM_FW-1:0] FW_NOFWD_MASK = NUM_FW'(1'b1),
  parameter int unsigned       STALL_CNT_W   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  UIntX                   regfile_i [32],
  input  logic                   flush_i,
  input  FwCtrl                  fw_i [NUM_FW],
  operand_select_stage_if.slave  bus,
  output logic                   hazard_stall_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  RegIdx rs1_s;
  RegIdx rs2_s;
  UIntX  rs1_val_s;
  UIntX  rs2_val_s;
  logic  rs1_blk_s;
  logic  rs2_blk_s;
  UIntX  op1_s;
  UIntX  op2_s;
  logic  hazard_s;
  logic  in_ready_s;
  logic  accept_s;

  logic      valid_q, valid_d;
  OutPayload out_q, out_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  assign rs1_s = rs1_of(bus.in_inst);
  assign rs2_s = rs2_of(bus.in_inst);

  fw_operand_resolve #(
    .NUM_FW       (NUM_FW),
    .FW_NOFWD_MASK(FW_NOFWD_MASK)
  ) u_rs1_resolve (
    .addr_i    (rs1_s),
    .regfile_i (regfile_i),
    .fw_i      (fw_i),
    .value_o   (rs1_val_s),
    .blocking_o(rs1_blk_s)
  );

  fw_operand_resolve #(
    .NUM_FW       (NUM_FW),
    .FW_NOFWD_MASK(FW_NOFWD_MASK)
  ) u_rs2_resolve (
    .addr_i    (rs2_s),
    .regfile_i (regfile_i),
    .fw_i      (fw_i),
    .value_o   (rs2_val_s),
    .blocking_o(rs2_blk_s)
  );

  // Operand muxes; unlisted select encodings produce zero.
  always_comb begin
    op1_s = '0;
    op2_s = '0;
    case (bus.in_ctrl.op1_sel)
      OP1_RS1: op1_s = rs1_val_s;
      OP1_PC:  op1_s = bus.in_pc;
      OP1_IMZ: op1_s = bus.in_imm_z;
      default: op1_s = '0;
    endcase
    case (bus.in_ctrl.op2_sel)
      OP2_RS2W: op2_s = rs2_val_s;
      OP2_IMI:  op2_s = bus.in_imm_i;
      OP2_IMS:  op2_s = bus.in_imm_s;
      OP2_IMJ:  op2_s = bus.in_imm_j;
      OP2_IMU:  op2_s = bus.in_imm_u;
      default:  op2_s = '0;
    endcase
  end

  assign hazard_s   = bus.in_valid & (rs1_blk_s | rs2_blk_s);
  assign in_ready_s = ~hazard_s & (~valid_q | bus.out_ready);
  assign accept_s   = bus.in_valid & in_ready_s & ~flush_i;

  // Output register next state: flush kills, accept loads (draining concurrently), a taken output empties.
  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (accept_s) begin
      valid_d          = 1'b1;
      out_d.pc         = bus.in_pc;
      out_d.inst       = bus.in_inst;
      out_d.inst_id    = bus.in_inst_id;
      out_d.ctrl       = bus.in_ctrl;
      out_d.imm_i      = bus.in_imm_i;
      out_d.imm_b      = bus.in_imm_b;
      out_d.imm_j      = bus.in_imm_j;
      out_d.op1_data   = op1_s;
      out_d.op2_data   = op2_s;
      out_d.rs2_data   = rs2_val_s;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Stall counter saturates at all-ones and is not affected by flush.
  always_comb begin
    stall_d = stall_q;
    if (hazard_s && !(&stall_q)) begin
      stall_d = stall_q + STALL_CNT_W'(1'b1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      stall_q <= stall_d;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.out_valid    = valid_q;
  assign bus.out_pc       = out_q.pc;
  assign bus.out_inst     = out_q.inst;
  assign bus.out_inst_id  = out_q.inst_id;
  assign bus.out_ctrl     = out_q.ctrl;
  assign bus.out_imm_i    = out_q.imm_i;
  assign bus.out_imm_b    = out_q.imm_b;
  assign bus.out_imm_j    = out_q.imm_j;
  assign bus.out_op1_data = out_q.op1_data;
  assign bus.out_op2_data = out_q.op2_data;
  assign bus.out_rs2_data = out_q.rs2_data;
  assign hazard_stall_o   = hazard_s;
  assign stall_cycles_o   = stall_q;

endmodule

// File: tb/tb_operand_select_stage.sv
// Randomised and directed bench for operand_select_stage against a queue-based
// reference model of the stage.
module tb_operand_select_stage;
  import operand_select_stage_pkg::*;

  localparam int unsigned NUM_FW = 3;
  localparam logic [NUM_FW-1:0] MASK = 3'b001;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};
  localparam int PW = $bits(OutPayload);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  UIntX          regfile [32];
  FwCtrl         fw [NUM_FW];
  logic          hazard_stall;
  logic [CW-1:0] stall_cycles;
  logic          chk_en;

  int total = 0;
  int bad   = 0;

  operand_select_stage_if bus ();

  operand_select_stage #(
    .NUM_FW       (NUM_FW),
    .FW_NOFWD_MASK(MASK),
    .STALL_CNT_W  (CW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .regfile_i     (regfile),
    .flush_i       (flush),
    .fw_i          (fw),
    .bus           (bus),
    .hazard_stall_o(hazard_stall),
    .stall_cycles_o(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_pl(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: value a register read must deliver.
  function automatic UIntX m_operand(input RegIdx r);
    if (r == 5'd0) return '0;
    for (int i = 0; i < NUM_FW; i++) begin
      if (fw[i].valid && fw[i].addr == r && fw[i].can_forward && !MASK[i]) return fw[i].wdata;
    end
    return regfile[r];
  endfunction

  function automatic logic m_hazard();
    RegIdx r1 = bus.in_inst[19:15];
    RegIdx r2 = bus.in_inst[24:20];
    logic h = 1'b0;
    for (int i = 0; i < NUM_FW; i++) begin
      if (fw[i].valid && (!fw[i].can_forward || MASK[i]) &&
          ((fw[i].addr == r1 && r1 != 5'd0) || (fw[i].addr == r2 && r2 != 5'd0))) h = 1'b1;
    end
    return bus.in_valid && h;
  endfunction

  function automatic OutPayload m_payload();
    OutPayload p;
    p.pc       = bus.in_pc;
    p.inst     = bus.in_inst;
    p.inst_id  = bus.in_inst_id;
    p.ctrl     = bus.in_ctrl;
    p.imm_i    = bus.in_imm_i;
    p.imm_b    = bus.in_imm_b;
    p.imm_j    = bus.in_imm_j;
    p.rs2_data = m_operand(bus.in_inst[24:20]);
    p.op1_data = (bus.in_ctrl.op1_sel == OP1_RS1) ? m_operand(bus.in_inst[19:15]) :
                 (bus.in_ctrl.op1_sel == OP1_PC)  ? bus.in_pc :
                 (bus.in_ctrl.op1_sel == OP1_IMZ) ? bus.in_imm_z : 32'd0;
    p.op2_data = (bus.in_ctrl.op2_sel == OP2_RS2W) ? p.rs2_data :
                 (bus.in_ctrl.op2_sel == OP2_IMI)  ? bus.in_imm_i :
                 (bus.in_ctrl.op2_sel == OP2_IMS)  ? bus.in_imm_s :
                 (bus.in_ctrl.op2_sel == OP2_IMJ)  ? bus.in_imm_j :
                 (bus.in_ctrl.op2_sel == OP2_IMU)  ? bus.in_imm_u : 32'd0;
    return p;
  endfunction

  function automatic OutPayload dut_payload();
    OutPayload p;
    p.pc       = bus.out_pc;
    p.inst     = bus.out_inst;
    p.inst_id  = bus.out_inst_id;
    p.ctrl     = bus.out_ctrl;
    p.imm_i    = bus.out_imm_i;
    p.imm_b    = bus.out_imm_b;
    p.imm_j    = bus.out_imm_j;
    p.op1_data = bus.out_op1_data;
    p.op2_data = bus.out_op2_data;
    p.rs2_data = bus.out_rs2_data;
    return p;
  endfunction

  // Model state: a one-deep output queue and the expected stall count.
  OutPayload     exp_q [$];
  logic [CW-1:0] exp_stall;

  always @(posedge clk) begin : model
    logic      acc;
    OutPayload p;
    if (!rst_n) begin
      exp_q.delete();
      exp_stall <= '0;
    end else begin
      acc = bus.in_valid && !m_hazard() && (exp_q.size() == 0 || bus.out_ready) && !flush;
      p   = m_payload();
      if (m_hazard() && exp_stall != CMAX) exp_stall <= exp_stall + 4'd1;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() != 0 && bus.out_ready) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(p);
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hazard_stall", 32'(hazard_stall), 32'(m_hazard()));
      chk("in_ready", 32'(bus.in_ready),
          32'(!m_hazard() && (exp_q.size() == 0 || bus.out_ready)));
      chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
      chk("stall_cycles", 32'(stall_cycles), 32'(exp_stall));
      if (exp_q.size() != 0) chk_pl("payload", dut_payload(), exp_q[0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    for (int i = 0; i < NUM_FW; i++) fw[i] = '0;
  endtask

  task automatic set_inst(input RegIdx rs1, input RegIdx rs2, input Op1Sel s1, input Op2Sel s2,
                          input IId id);
    bus.in_inst          = {7'd0, rs2, rs1, 3'd0, 5'd1, 7'h13};
    bus.in_pc            = 32'h1000 + 32'(id) * 32'd4;
    bus.in_inst_id       = id;
    bus.in_ctrl.op1_sel  = s1;
    bus.in_ctrl.op2_sel  = s2;
    bus.in_ctrl.alu_op   = 4'(id);
    bus.in_ctrl.rf_we    = 1'b1;
    bus.in_imm_i         = 32'd3;
    bus.in_imm_s         = 32'd5;
    bus.in_imm_b         = 32'd8;
    bus.in_imm_j         = 32'h20;
    bus.in_imm_u         = 32'h1000;
    bus.in_imm_z         = 32'h1F;
  endtask

  task automatic set_rand_inst();
    set_inst(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             Op1Sel'(2'($urandom_range(0, 3))), Op2Sel'(3'($urandom_range(0, 7))),
             8'($urandom));
    bus.in_pc    = $urandom;
    bus.in_imm_i = $urandom;
    bus.in_imm_s = $urandom;
    bus.in_imm_b = $urandom;
    bus.in_imm_j = $urandom;
    bus.in_imm_u = $urandom;
    bus.in_imm_z = $urandom;
  endtask

  initial begin
    rst_n  = 1'b0;
    chk_en = 1'b0;
    idle();
    set_inst(5'd0, 5'd0, OP1_RS1, OP2_IMI, 8'd0);
    for (int r = 0; r < 32; r++) regfile[r] = $urandom;
    regfile[5] = 32'h10;
    regfile[6] = 32'h66;
    cyc();
    cyc();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_op1", bus.out_op1_data, 32'd0);
    chk("rst_pc", bus.out_pc, 32'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Back-to-back ADDI from x5.
    set_inst(5'd5, 5'd0, OP1_RS1, OP2_IMI, 8'd1);
    bus.in_valid = 1'b1;
    cyc();
    chk("addi1_valid", 32'(bus.out_valid), 32'd1);
    chk("addi1_op1", bus.out_op1_data, 32'h10);
    chk("addi1_op2", bus.out_op2_data, 32'd3);
    set_inst(5'd5, 5'd0, OP1_RS1, OP2_IMI, 8'd2);
    cyc();
    chk("addi2_id", 32'(bus.out_inst_id), 32'd2);
    chk("addi2_op1", bus.out_op1_data, 32'h10);

    // Forwarding priority.
    set_inst(5'd5, 5'd0, OP1_RS1, OP2_IMI, 8'd3);
    fw[1] = '{valid: 1'b1, can_forward: 1'b1, addr: 5'd5, wdata: 32'hAA};
    fw[2] = '{valid: 1'b1, can_forward: 1'b1, addr: 5'd5, wdata: 32'hBB};
    cyc();
    chk("fw1_op1", bus.out_op1_data, 32'hAA);
    fw[1].valid = 1'b0;
    set_inst(5'd5, 5'd0, OP1_RS1, OP2_IMI, 8'd4);
    cyc();
    chk("fw2_op1", bus.out_op1_data, 32'hBB);

    // Masked source 0 stalls for three cycles.
    idle();
    cyc();
    set_inst(5'd5, 5'd6, OP1_RS1, OP2_RS2W, 8'd5);
    bus.in_valid = 1'b1;
    fw[0] = '{valid: 1'b1, can_forward: 1'b1, addr: 5'd6, wdata: 32'hDEAD};
    #1;
    chk("stall_haz", 32'(hazard_stall), 32'd1);
    chk("stall_rdy", 32'(bus.in_ready), 32'd0);
    repeat (3) cyc();
    chk("stall_cnt3", 32'(stall_cycles), 32'd3);
    chk("stall_noacc", 32'(bus.out_valid), 32'd0);
    fw[0].valid = 1'b0;
    #1;
    chk("stall_clr_haz", 32'(hazard_stall), 32'd0);
    chk("stall_clr_rdy", 32'(bus.in_ready), 32'd1);
    cyc();
    chk("stall_acc_id", 32'(bus.out_inst_id), 32'd5);
    chk("stall_acc_op2", bus.out_op2_data, 32'h66);
    chk("stall_acc_cnt", 32'(stall_cycles), 32'd3);

    // Backpressure holds the output.
    bus.out_ready = 1'b0;
    set_inst(5'd0, 5'd0, OP1_PC, OP2_IMU, 8'd6);
    repeat (4) begin
      cyc();
      chk("bp_id", 32'(bus.out_inst_id), 32'd5);
      chk("bp_op2", bus.out_op2_data, 32'h66);
      chk("bp_rdy", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
    cyc();
    chk("bp_next_id", 32'(bus.out_inst_id), 32'd6);
    chk("bp_next_op1", bus.out_op1_data, 32'h1018);
    chk("bp_next_op2", bus.out_op2_data, 32'h1000);

    // Flush with a held output and an incoming instruction.
    set_inst(5'd5, 5'd0, OP1_IMZ, OP2_IMS, 8'd7);
    flush = 1'b1;
    cyc();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    cyc();
    chk("flush_valid2", 32'(bus.out_valid), 32'd0);

    // x0 never hazards and reads as zero.
    set_inst(5'd0, 5'd0, OP1_RS1, OP2_RS2W, 8'd8);
    bus.in_valid = 1'b1;
    fw[0] = '{valid: 1'b1, can_forward: 1'b0, addr: 5'd0, wdata: 32'h55};
    #1;
    chk("x0_haz", 32'(hazard_stall), 32'd0);
    chk("x0_rdy", 32'(bus.in_ready), 32'd1);
    cyc();
    chk("x0_valid", 32'(bus.out_valid), 32'd1);
    chk("x0_op1", bus.out_op1_data, 32'd0);
    chk("x0_rs2", bus.out_rs2_data, 32'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      set_rand_inst();
      for (int i = 0; i < NUM_FW; i++) begin
        fw[i].valid       = 1'($urandom_range(0, 1));
        fw[i].can_forward = ($urandom_range(0, 3) != 0);
        fw[i].addr        = 5'($urandom_range(0, 7));
        fw[i].wdata       = $urandom;
      end
      if ($urandom_range(0, 7) == 0) regfile[$urandom_range(1, 31)] = $urandom;
      cyc();
    end
    chk("sat_cnt", 32'(stall_cycles), 32'hF);

    // Reset in the middle of a transfer.
    idle();
    set_inst(5'd5, 5'd0, OP1_RS1, OP2_IMI, 8'd9);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    cyc();
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    cyc();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_stall", 32'(stall_cycles), 32'd0);
    chk("mid_rst_op1", bus.out_op1_data, 32'd0);
    rst_n = 1'b1;
    idle();
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
